remote_load_resp_router: RTL and testbench

Steering stage between the endpoint's returned-packet FIFO and the vanilla core's writeback ports. Each cycle it drains at most one returned packet and classifies it. Credit returns are dropped, and instruction fetches become a one-cycle ifetch pulse. Integer and float load data go into per-destination buffers. The buffers present responses to the core with a force flag when the core must take them immediately.

---
 rtl/remote_load_resp_router_if.sv | 48 ++++
 rtl/remote_load_resp_router.sv | 144 ++++++++++++++
 tb/tb_remote_load_resp_router.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/remote_load_resp_router_if.sv
// Returned-packet channel from the endpoint plus the int/float writeback heads toward the core.
// Signal suffixes are named from the router's point of view.
interface remote_load_resp_router_if #(
    parameter int unsigned data_width_p     = 32,
    parameter int unsigned reg_addr_width_p = 5
);
    logic                        returned_v_i;
    logic [data_width_p-1:0]     returned_data_i;
    logic [reg_addr_width_p-1:0] returned_reg_id_i;
    logic [1:0]                  returned_pkt_type_i;
    logic                        returned_fifo_full_i;
    logic                        returned_yumi_o;

    logic                        ifetch_v_o;
    logic [data_width_p-1:0]     ifetch_instr_o;

    logic                        int_remote_load_resp_v_o;
    logic [reg_addr_width_p-1:0] int_remote_load_resp_rd_o;
    logic [data_width_p-1:0]     int_remote_load_resp_data_o;
    logic                        int_remote_load_resp_force_o;
    logic                        int_remote_load_resp_yumi_i;

    logic                        float_remote_load_resp_v_o;
    logic [reg_addr_width_p-1:0] float_remote_load_resp_rd_o;
    logic [data_width_p-1:0]     float_remote_load_resp_data_o;
    logic                        float_remote_load_resp_force_o;
    logic                        float_remote_load_resp_yumi_i;

    modport master (
        output returned_v_i, returned_data_i, returned_reg_id_i, returned_pkt_type_i,
        output returned_fifo_full_i, int_remote_load_resp_yumi_i, float_remote_load_resp_yumi_i,
        input  returned_yumi_o, ifetch_v_o, ifetch_instr_o,
        input  int_remote_load_resp_v_o, int_remote_load_resp_rd_o,
        input  int_remote_load_resp_data_o, int_remote_load_resp_force_o,
        input  float_remote_load_resp_v_o, float_remote_load_resp_rd_o,
        input  float_remote_load_resp_data_o, float_remote_load_resp_force_o
    );

    modport slave (
        input  returned_v_i, returned_data_i, returned_reg_id_i, returned_pkt_type_i,
        input  returned_fifo_full_i, int_remote_load_resp_yumi_i, float_remote_load_resp_yumi_i,
        output returned_yumi_o, ifetch_v_o, ifetch_instr_o,
        output int_remote_load_resp_v_o, int_remote_load_resp_rd_o,
        output int_remote_load_resp_data_o, int_remote_load_resp_force_o,
        output float_remote_load_resp_v_o, float_remote_load_resp_rd_o,
        output float_remote_load_resp_data_o, float_remote_load_resp_force_o
    );
endinterface

// File: rtl/remote_load_resp_router.sv
// Drains one returned packet per cycle: credits dropped, ifetches pulsed, int/float load data
// buffered per destination and presented to the core with a force flag.
module remote_load_resp_router #(
    parameter int unsigned data_width_p     = 32,
    parameter int unsigned reg_addr_width_p = 5,
    parameter int unsigned buf_els_p        = 2,
    parameter int unsigned stall_limit_p    = 16
) (
    input logic                     clk_i,
    input logic                     reset_i,
    remote_load_resp_router_if.slave bus_io
);
    localparam int unsigned PtrW  = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;
    localparam int unsigned CntW  = $clog2(buf_els_p + 1);
    localparam int unsigned WaitW = $clog2(stall_limit_p + 1);
    localparam logic [CntW-1:0]  CntFull = CntW'(buf_els_p);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(stall_limit_p);
    localparam logic [PtrW-1:0]  PtrLast = PtrW'(buf_els_p - 1);

    typedef enum logic [1:0] {
        PktCredit  = 2'd0,
        PktIntWb   = 2'd1,
        PktFloatWb = 2'd2,
        PktIfetch  = 2'd3
    } pkt_type_e;

    // Path index 0 is the integer buffer, 1 the float buffer.
    logic [CntW-1:0]             cnt_q      [2];
    logic [CntW-1:0]             cnt_d      [2];
    logic [PtrW-1:0]             wptr_q     [2];
    logic [PtrW-1:0]             wptr_d     [2];
    logic [PtrW-1:0]             rptr_q     [2];
    logic [PtrW-1:0]             rptr_d     [2];
    logic [WaitW-1:0]            wait_q     [2];
    logic [WaitW-1:0]            wait_d     [2];
    logic [reg_addr_width_p-1:0] rd_mem_q   [2][buf_els_p];
    logic [reg_addr_width_p-1:0] rd_mem_d   [2][buf_els_p];
    logic [data_width_p-1:0]     data_mem_q [2][buf_els_p];
    logic [data_width_p-1:0]     data_mem_d [2][buf_els_p];

    logic                    ifetch_v_q, ifetch_v_d;
    logic [data_width_p-1:0] ifetch_instr_q, ifetch_instr_d;

    pkt_type_e  pkt_type;
    logic       ready;
    logic       accept;
    logic [1:0] full;
    logic [1:0] head_v;
    logic [1:0] enq;
    logic [1:0] deq;
    logic [1:0] force_v;
    logic [1:0] core_yumi;

    assign pkt_type  = pkt_type_e'(bus_io.returned_pkt_type_i);
    assign core_yumi = {bus_io.float_remote_load_resp_yumi_i, bus_io.int_remote_load_resp_yumi_i};

    // Readiness uses start-of-cycle occupancy only, so acceptance never sees the core's yumi.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            full[p]    = (cnt_q[p] == CntFull);
            head_v[p]  = (cnt_q[p] != '0);
            deq[p]     = core_yumi[p] & head_v[p];
            force_v[p] = head_v[p] &
                         (full[p] | (wait_q[p] == WaitMax) | bus_io.returned_fifo_full_i);
        end
        unique case (pkt_type)
            PktIntWb:   ready = ~full[0];
            PktFloatWb: ready = ~full[1];
            default:    ready = 1'b1;
        endcase
        accept = bus_io.returned_v_i & ready & ~reset_i;
        enq[0] = accept & (pkt_type == PktIntWb);
        enq[1] = accept & (pkt_type == PktFloatWb);
    end

    always_comb begin
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        wait_d     = wait_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        for (int p = 0; p < 2; p++) begin
            if (enq[p]) begin
                rd_mem_d[p][wptr_q[p]]   = bus_io.returned_reg_id_i;
                data_mem_d[p][wptr_q[p]] = bus_io.returned_data_i;
                wptr_d[p] = (wptr_q[p] == PtrLast) ? '0 : wptr_q[p] + PtrW'(1);
            end
            if (deq[p]) begin
                rptr_d[p] = (rptr_q[p] == PtrLast) ? '0 : rptr_q[p] + PtrW'(1);
            end
            unique case ({enq[p], deq[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + CntW'(1);
                2'b01:   cnt_d[p] = cnt_q[p] - CntW'(1);
                default: cnt_d[p] = cnt_q[p];
            endcase
            if (deq[p] || !head_v[p]) begin
                wait_d[p] = '0;
            end else if (wait_q[p] != WaitMax) begin
                wait_d[p] = wait_q[p] + WaitW'(1);
            end
        end
        ifetch_v_d     = accept & (pkt_type == PktIfetch);
        ifetch_instr_d = ifetch_v_d ? bus_io.returned_data_i : ifetch_instr_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q          <= '{default: '0};
            wptr_q         <= '{default: '0};
            rptr_q         <= '{default: '0};
            wait_q         <= '{default: '0};
            ifetch_v_q     <= 1'b0;
            ifetch_instr_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            wait_q         <= wait_d;
            ifetch_v_q     <= ifetch_v_d;
            ifetch_instr_q <= ifetch_instr_d;
        end
    end

    // Storage needs no reset; occupancy gates every use of it.
    always_ff @(posedge clk_i) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign bus_io.returned_yumi_o = accept;
    assign bus_io.ifetch_v_o      = ifetch_v_q;
    assign bus_io.ifetch_instr_o  = ifetch_instr_q;

    assign bus_io.int_remote_load_resp_v_o     = head_v[0];
    assign bus_io.int_remote_load_resp_rd_o    = rd_mem_q[0][rptr_q[0]];
    assign bus_io.int_remote_load_resp_data_o  = data_mem_q[0][rptr_q[0]];
    assign bus_io.int_remote_load_resp_force_o = force_v[0];

    assign bus_io.float_remote_load_resp_v_o     = head_v[1];
    assign bus_io.float_remote_load_resp_rd_o    = rd_mem_q[1][rptr_q[1]];
    assign bus_io.float_remote_load_resp_data_o  = data_mem_q[1][rptr_q[1]];
    assign bus_io.float_remote_load_resp_force_o = force_v[1];
endmodule

// File: tb/tb_remote_load_resp_router.sv
// Scoreboard bench for remote_load_resp_router: per-path expected queues filled on acceptance,
// compared against the head outputs, plus directed checks of force, ifetch and reset.
module tb_remote_load_resp_router;
    localparam int unsigned Dw    = 32;
    localparam int unsigned Rw    = 5;
    localparam int unsigned Els   = 2;
    localparam int unsigned Limit = 16;

    localparam logic [1:0] TCredit = 2'd0;
    localparam logic [1:0] TInt    = 2'd1;
    localparam logic [1:0] TFloat  = 2'd2;
    localparam logic [1:0] TIfetch = 2'd3;

    typedef struct packed {
        logic [Rw-1:0] rd;
        logic [Dw-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    remote_load_resp_router_if #(.data_width_p(Dw), .reg_addr_width_p(Rw)) bus ();

    remote_load_resp_router #(
        .data_width_p    (Dw),
        .reg_addr_width_p(Rw),
        .buf_els_p       (Els),
        .stall_limit_p   (Limit)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t          iq[$];
    ent_t          fq[$];
    int            iwait;
    int            fwait;
    logic          exp_ifv;
    logic [Dw-1:0] exp_instr;

    logic obs_yumi;
    logic obs_int_v;
    logic obs_int_force;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1: drive one cycle of stimulus, check against the model, advance.
    task automatic cycle(input logic v, input logic [1:0] typ, input logic [Rw-1:0] rd,
                         input logic [Dw-1:0] data, input logic iy, input logic fy,
                         input logic ff);
        int   isz;
        int   fsz;
        logic rdy;
        logic exp_yumi;
        ent_t e;
        bus.returned_v_i                  = v;
        bus.returned_pkt_type_i           = typ;
        bus.returned_reg_id_i             = rd;
        bus.returned_data_i               = data;
        bus.int_remote_load_resp_yumi_i   = iy;
        bus.float_remote_load_resp_yumi_i = fy;
        bus.returned_fifo_full_i          = ff;
        #1;
        isz = iq.size();
        fsz = fq.size();
        case (typ)
            TInt:    rdy = (isz < Els);
            TFloat:  rdy = (fsz < Els);
            default: rdy = 1'b1;
        endcase
        exp_yumi = v & rdy;
        check_eq("returned_yumi", bus.returned_yumi_o, exp_yumi);
        check_eq("int_v", bus.int_remote_load_resp_v_o, isz != 0);
        if (isz != 0) begin
            check_eq("int_rd", bus.int_remote_load_resp_rd_o, iq[0].rd);
            check_eq("int_data", bus.int_remote_load_resp_data_o, iq[0].data);
        end
        check_eq("int_force", bus.int_remote_load_resp_force_o,
                 (isz != 0) && (isz == Els || iwait == Limit || ff));
        check_eq("float_v", bus.float_remote_load_resp_v_o, fsz != 0);
        if (fsz != 0) begin
            check_eq("float_rd", bus.float_remote_load_resp_rd_o, fq[0].rd);
            check_eq("float_data", bus.float_remote_load_resp_data_o, fq[0].data);
        end
        check_eq("float_force", bus.float_remote_load_resp_force_o,
                 (fsz != 0) && (fsz == Els || fwait == Limit || ff));
        check_eq("ifetch_v", bus.ifetch_v_o, exp_ifv);
        check_eq("ifetch_instr", bus.ifetch_instr_o, exp_instr);
        obs_yumi      = bus.returned_yumi_o;
        obs_int_v     = bus.int_remote_load_resp_v_o;
        obs_int_force = bus.int_remote_load_resp_force_o;

        if (iy && isz != 0) e = iq.pop_front();
        if (fy && fsz != 0) e = fq.pop_front();
        iwait = ((iy && isz != 0) || isz == 0) ? 0 : ((iwait < Limit) ? iwait + 1 : iwait);
        fwait = ((fy && fsz != 0) || fsz == 0) ? 0 : ((fwait < Limit) ? fwait + 1 : fwait);
        e.rd   = rd;
        e.data = data;
        if (exp_yumi && typ == TInt) iq.push_back(e);
        if (exp_yumi && typ == TFloat) fq.push_back(e);
        exp_ifv = exp_yumi && (typ == TIfetch);
        if (exp_ifv) exp_instr = data;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic iy, input logic fy);
        cycle(1'b0, TCredit, '0, '0, iy, fy, 1'b0);
    endtask

    // Reset with a live packet and fifo_full high, so gating of yumi and force is exercised.
    task automatic do_reset();
        reset                    = 1'b1;
        bus.returned_v_i         = 1'b1;
        bus.returned_pkt_type_i  = TInt;
        bus.returned_fifo_full_i = 1'b1;
        #1;
        check_eq("rst_yumi", bus.returned_yumi_o, 1'b0);
        @(posedge clk);
        #1;
        iq.delete();
        fq.delete();
        iwait     = 0;
        fwait     = 0;
        exp_ifv   = 1'b0;
        exp_instr = '0;
        check_eq("rst_int_v", bus.int_remote_load_resp_v_o, 1'b0);
        check_eq("rst_int_force", bus.int_remote_load_resp_force_o, 1'b0);
        check_eq("rst_float_v", bus.float_remote_load_resp_v_o, 1'b0);
        check_eq("rst_float_force", bus.float_remote_load_resp_force_o, 1'b0);
        check_eq("rst_ifetch_v", bus.ifetch_v_o, 1'b0);
        check_eq("rst_ifetch_instr", bus.ifetch_instr_o, 32'h0);
        reset                    = 1'b0;
        bus.returned_v_i         = 1'b0;
        bus.returned_fifo_full_i = 1'b0;
    endtask

    initial begin
        int stall_cnt;
        logic seen;
        reset                             = 1'b1;
        bus.returned_v_i                  = 1'b0;
        bus.returned_data_i               = '0;
        bus.returned_reg_id_i             = '0;
        bus.returned_pkt_type_i           = TCredit;
        bus.returned_fifo_full_i          = 1'b0;
        bus.int_remote_load_resp_yumi_i   = 1'b0;
        bus.float_remote_load_resp_yumi_i = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single int response, then yumi.
        cycle(1'b1, TInt, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        check_eq("t1_accept", obs_yumi, 1'b1);
        idle(1'b1, 1'b0);
        check_eq("t1_head_v", obs_int_v, 1'b1);
        idle(1'b0, 1'b0);
        check_eq("t1_drained", obs_int_v, 1'b0);

        // Float buffer fills; third packet held until a yumi frees a slot.
        cycle(1'b1, TFloat, 5'd1, 32'hF0000001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, TFloat, 5'd2, 32'hF0000002, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, TFloat, 5'd3, 32'hF0000003, 1'b0, 1'b0, 1'b0);
        check_eq("float_third_held", obs_yumi, 1'b0);
        cycle(1'b1, TFloat, 5'd3, 32'hF0000003, 1'b0, 1'b1, 1'b0);
        check_eq("float_held_on_yumi", obs_yumi, 1'b0);
        cycle(1'b1, TFloat, 5'd3, 32'hF0000003, 1'b0, 1'b0, 1'b0);
        check_eq("float_third_accepted", obs_yumi, 1'b1);
        repeat (3) idle(1'b0, 1'b1);

        // Stall limit: force stays low for Limit cycles of valid head.
        cycle(1'b1, TInt, 5'd9, 32'h12345678, 1'b0, 1'b0, 1'b0);
        stall_cnt = 0;
        seen      = 1'b0;
        for (int i = 0; i < Limit + 4; i++) begin
            idle(1'b0, 1'b0);
            if (!seen) begin
                if (obs_int_force) seen = 1'b1;
                else if (obs_int_v) stall_cnt++;
            end
        end
        check_eq("stall_len", stall_cnt, Limit);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        check_eq("stall_cleared_force", obs_int_force, 1'b0);

        // Ifetch then credit, back to back.
        cycle(1'b1, TIfetch, 5'd0, 32'h00000013, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, TCredit, 5'd0, 32'hAAAA5555, 1'b0, 1'b0, 1'b0);
        check_eq("credit_accepted", obs_yumi, 1'b1);
        repeat (2) idle(1'b0, 1'b0);

        // Interleaved traffic: each buffer holds one entry with enqueue and dequeue together.
        cycle(1'b1, TInt, 5'd20, 32'h11110000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, TFloat, 5'd21, 32'h22220000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0)
                cycle(1'b1, TInt, 5'($urandom_range(0, 31)), $urandom, 1'b1, 1'b0, 1'b0);
            else
                cycle(1'b1, TFloat, 5'($urandom_range(0, 31)), $urandom, 1'b0, 1'b1, 1'b0);
        end
        repeat (2) idle(1'b1, 1'b1);

        // Endpoint FIFO full forces a valid head immediately.
        cycle(1'b1, TInt, 5'd7, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check_eq("pre_ffull_force", obs_int_force, 1'b0);
        cycle(1'b0, TCredit, '0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("ffull_force", obs_int_force, 1'b1);

        // Mid-stream reset discards buffered responses.
        cycle(1'b1, TFloat, 5'd8, 32'hBADC0FFE, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, TIfetch, 5'd0, 32'h00100073, 1'b0, 1'b0, 1'b0);
        do_reset();
        repeat (2) idle(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
